// File: rtl/race_datapath.sv
`default_nettype none
// ============================================================================
// Module      : race_datapath
// Description : Scan counters, pixel generation and car position for the racer.
// Revision    : 1.0
// ============================================================================
module race_datapath #(
    parameter int ROAD_L = 30,
    parameter int ROAD_W = 100,
    parameter int SIDE_W = 30,
    parameter int SCR_H  = 120,
    parameter int CAR_W  = 5,
    parameter int CAR_H  = 13,
    parameter int CAR_Y0 = 100,
    parameter int CAR_X0 = 78,
    parameter int STEP   = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       draw_bg_green_left,
    input  logic       draw_bg_black,
    input  logic       draw_bg_green_right,
    input  logic       draw_car,
    input  logic       erase,
    input  logic       update_car,
    input  logic       inc,
    input  logic       left,
    input  logic       right,
    output logic [7:0] counterx,
    output logic [7:0] countery,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot
);

    localparam logic [2:0] c_mode_idle  = 3'd0;
    localparam logic [2:0] c_mode_gl    = 3'd1;
    localparam logic [2:0] c_mode_black = 3'd2;
    localparam logic [2:0] c_mode_gr    = 3'd3;
    localparam logic [2:0] c_mode_car   = 3'd4;
    localparam logic [2:0] c_mode_upd   = 3'd5;
    localparam logic [2:0] c_mode_erase = 3'd6;

    localparam logic [1:0] c_pend_none  = 2'd0;
    localparam logic [1:0] c_pend_left  = 2'd1;
    localparam logic [1:0] c_pend_right = 2'd2;

    localparam logic [7:0] c_side_w = 8'(SIDE_W);
    localparam logic [7:0] c_road_w = 8'(ROAD_W);
    localparam logic [7:0] c_road_l = 8'(ROAD_L);
    localparam logic [7:0] c_road_r = 8'(ROAD_L + ROAD_W);
    localparam logic [7:0] c_scr_h  = 8'(SCR_H);
    localparam logic [7:0] c_car_w  = 8'(CAR_W);
    localparam logic [7:0] c_car_h  = 8'(CAR_H);
    localparam logic [6:0] c_car_y0 = 7'(CAR_Y0);
    localparam logic [7:0] c_car_x0 = 8'(CAR_X0);

    localparam logic signed [9:0] c_car_min = 10'(ROAD_L);
    localparam logic signed [9:0] c_car_max = 10'(ROAD_L + ROAD_W - CAR_W);
    localparam logic signed [9:0] c_step    = 10'(STEP);

    localparam logic [2:0] c_green = 3'b010;
    localparam logic [2:0] c_black = 3'b000;
    localparam logic [2:0] c_red   = 3'b100;

    logic [2:0]        w_mode;
    logic [2:0]        r_prev_mode;
    logic              w_first;
    logic [7:0]        r_cx;
    logic [7:0]        r_cy;
    logic [7:0]        w_cx;
    logic [7:0]        w_cy;
    logic [7:0]        w_width;
    logic [7:0]        w_height;
    logic [7:0]        w_base_x;
    logic [6:0]        w_base_y;
    logic [2:0]        w_colour;
    logic              w_valid;
    logic [7:0]        r_car_x;
    logic [1:0]        r_pend;
    logic              w_erase_first;
    logic signed [9:0] w_car_sum;
    logic [7:0]        w_car_next;

    always_comb begin
        w_mode = c_mode_idle;
        if (erase)                    w_mode = c_mode_erase;
        else if (update_car)          w_mode = c_mode_upd;
        else if (draw_car)            w_mode = c_mode_car;
        else if (draw_bg_black)       w_mode = c_mode_black;
        else if (draw_bg_green_left)  w_mode = c_mode_gl;
        else if (draw_bg_green_right) w_mode = c_mode_gr;
    end

    // A mode change restarts the sweep without waiting a cycle for the registers.
    assign w_first       = (w_mode != r_prev_mode);
    assign w_cx          = w_first ? 8'd0 : r_cx;
    assign w_cy          = w_first ? 8'd0 : r_cy;
    assign counterx      = w_cx;
    assign countery      = w_cy;
    assign w_erase_first = (w_mode == c_mode_erase) && w_first;

    always_comb begin
        w_width  = 8'd0;
        w_height = 8'd0;
        w_base_x = 8'd0;
        w_base_y = 7'd0;
        w_colour = c_black;
        case (w_mode)
            c_mode_gl: begin
                w_width  = c_side_w;
                w_height = c_scr_h;
                w_colour = c_green;
            end
            c_mode_black, c_mode_erase: begin
                w_width  = c_road_w;
                w_height = c_scr_h;
                w_base_x = c_road_l;
            end
            c_mode_gr: begin
                w_width  = c_side_w;
                w_height = c_scr_h;
                w_base_x = c_road_r;
                w_colour = c_green;
            end
            c_mode_car, c_mode_upd: begin
                w_width  = c_car_w;
                w_height = c_car_h;
                w_base_x = r_car_x;
                w_base_y = c_car_y0;
                w_colour = c_red;
            end
            default: ;
        endcase
    end

    assign w_valid = (w_mode != c_mode_idle) && (w_cx < w_width) && (w_cy < w_height);

    always_comb begin
        w_car_sum = $signed({2'b00, r_car_x});
        if (r_pend == c_pend_left)       w_car_sum = w_car_sum - c_step;
        else if (r_pend == c_pend_right) w_car_sum = w_car_sum + c_step;
        if (w_car_sum < c_car_min)       w_car_next = c_car_min[7:0];
        else if (w_car_sum > c_car_max)  w_car_next = c_car_max[7:0];
        else                             w_car_next = w_car_sum[7:0];
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_prev_mode <= c_mode_idle;
            r_cx        <= 8'd0;
            r_cy        <= 8'd0;
            r_car_x     <= c_car_x0;
            r_pend      <= c_pend_none;
            x           <= 8'd0;
            y           <= 7'd0;
            colour      <= 3'b000;
            plot        <= 1'b0;
        end else begin
            r_prev_mode <= w_mode;
            if (w_mode == c_mode_idle) begin
                r_cx <= 8'd0;
                r_cy <= 8'd0;
            end else if (inc) begin
                r_cx <= 8'd0;
                r_cy <= w_cy + 8'd1;
            end else begin
                r_cx <= w_cx + 8'd1;
                r_cy <= w_cy;
            end
            // A pulse coinciding with the erase start is kept for the next erase.
            if (left && !right)      r_pend <= c_pend_left;
            else if (right && !left) r_pend <= c_pend_right;
            else if (w_erase_first)  r_pend <= c_pend_none;
            if (w_erase_first) r_car_x <= w_car_next;
            x      <= w_base_x + w_cx;
            y      <= w_base_y + w_cy[6:0];
            colour <= w_colour;
            plot   <= w_valid;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_race_datapath.sv
`default_nettype none
// ============================================================================
// Module      : tb_race_datapath
// Description : Self-checking bench: vector table, directed sweeps, random run.
// Revision    : 1.0
// ============================================================================
module tb_race_datapath;

    localparam int ROAD_L = 30, ROAD_W = 100, SIDE_W = 30, SCR_H = 120;
    localparam int CAR_W = 5, CAR_H = 13, CAR_Y0 = 100, CAR_X0 = 78, STEP = 4;
    localparam int M_IDLE = 0, M_GL = 1, M_BLK = 2, M_GR = 3, M_CAR = 4, M_UPD = 5, M_ERASE = 6;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       draw_bg_green_left = 0, draw_bg_black = 0, draw_bg_green_right = 0;
    logic       draw_car = 0, erase = 0, update_car = 0;
    logic       inc = 0, left = 0, right = 0;
    logic [7:0] counterx, countery, x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;

    race_datapath dut (
        .clock(clock), .reset(reset),
        .draw_bg_green_left(draw_bg_green_left), .draw_bg_black(draw_bg_black),
        .draw_bg_green_right(draw_bg_green_right), .draw_car(draw_car),
        .erase(erase), .update_car(update_car), .inc(inc), .left(left), .right(right),
        .counterx(counterx), .countery(countery), .x(x), .y(y), .colour(colour), .plot(plot)
    );

    always #5 clock = ~clock;

    int n_cmp = 0, n_fail = 0;
    // Reference model state: the sweep position as plain integers plus car state.
    int m_prev = 0, m_col = 0, m_row = 0, m_car_x = CAR_X0, m_pend = 0;
    int e_plot = 0, e_x = 0, e_y = 0, e_col = 0, e_full = 0;
    int plot_cnt = 0, min_x, max_x, min_y, max_y;

    task automatic chk(input string nm, input int act, input int exp_v);
        n_cmp++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp_v, $time);
        end
    endtask

    function automatic int pick();
        if (erase)               return M_ERASE;
        if (update_car)          return M_UPD;
        if (draw_car)            return M_CAR;
        if (draw_bg_black)       return M_BLK;
        if (draw_bg_green_left)  return M_GL;
        if (draw_bg_green_right) return M_GR;
        return M_IDLE;
    endfunction

    function automatic int clamp(input int v);
        if (v < ROAD_L) return ROAD_L;
        if (v > ROAD_L + ROAD_W - CAR_W) return ROAD_L + ROAD_W - CAR_W;
        return v;
    endfunction

    task automatic set_mask(input logic [5:0] m);
        {erase, update_car, draw_car, draw_bg_black, draw_bg_green_left, draw_bg_green_right} = m;
    endtask

    task automatic set_mode(input int md);
        logic [5:0] m;
        case (md)
            M_GL:    m = 6'b000010;
            M_BLK:   m = 6'b000100;
            M_GR:    m = 6'b000001;
            M_CAR:   m = 6'b001000;
            M_UPD:   m = 6'b010000;
            M_ERASE: m = 6'b100000;
            default: m = 6'b000000;
        endcase
        set_mask(m);
    endtask

    task automatic clear_stats();
        plot_cnt = 0; min_x = 999; max_x = -1; min_y = 999; max_y = -1;
    endtask

    // One clock with the currently driven inputs, checked against the model.
    task automatic cyc();
        int md, cx, cy, w, h, bx, by, col;
        bit first, valid;
        #1;
        md = pick();
        first = (md != m_prev);
        cx = first ? 0 : m_col;
        cy = first ? 0 : m_row;
        chk("counterx", int'(counterx), cx);
        chk("countery", int'(countery), cy);
        w = 0; h = 0; bx = 0; by = 0; col = 0;
        case (md)
            M_GL:            begin w = SIDE_W; h = SCR_H; col = 2; end
            M_BLK, M_ERASE:  begin w = ROAD_W; h = SCR_H; bx = ROAD_L; end
            M_GR:            begin w = SIDE_W; h = SCR_H; bx = ROAD_L + ROAD_W; col = 2; end
            M_CAR, M_UPD:    begin w = CAR_W; h = CAR_H; bx = m_car_x; by = CAR_Y0; col = 4; end
            default: ;
        endcase
        valid = (md != M_IDLE) && (cx < w) && (cy < h);
        if (!reset) begin
            m_prev = M_IDLE; m_col = 0; m_row = 0; m_car_x = CAR_X0; m_pend = 0;
            e_plot = 0; e_x = 0; e_y = 0; e_col = 0; e_full = 1;
        end else begin
            e_plot = valid ? 1 : 0; e_full = 0;
            e_x = (bx + cx) % 256; e_y = (by + cy) % 128; e_col = col;
            if (md == M_IDLE) begin m_col = 0; m_row = 0; end
            else if (inc) begin m_col = 0; m_row = (cy + 1) % 256; end
            else begin m_col = (cx + 1) % 256; m_row = cy; end
            if (md == M_ERASE && first) begin
                if (m_pend != 0) m_car_x = clamp(m_car_x + m_pend * STEP);
                m_pend = 0;
            end
            if (left && !right) m_pend = -1;
            else if (right && !left) m_pend = 1;
            m_prev = md;
        end
        @(posedge clock);
        #1;
        chk("plot", int'(plot), e_plot);
        if (e_plot == 1 || e_full == 1) begin
            chk("x", int'(x), e_x);
            chk("y", int'(y), e_y);
            chk("colour", int'(colour), e_col);
        end
        if (plot) begin
            plot_cnt++;
            if (int'(x) < min_x) min_x = int'(x);
            if (int'(x) > max_x) max_x = int'(x);
            if (int'(y) < min_y) min_y = int'(y);
            if (int'(y) > max_y) max_y = int'(y);
        end
    endtask

    // Acts as the control FSM: holds a mode, pulses inc at the row end, stops at stop_row.
    task automatic run_region(input int md, input int w, input int stop_row, input int budget);
        bit done = 0;
        for (int i = 0; i < budget; i++) begin
            set_mode(md); inc = 0;
            #1;
            if (int'(countery) == stop_row && i > 0) begin done = 1; break; end
            inc = (int'(counterx) == w - 1);
            cyc();
        end
        inc = 0;
        chk("sweep_reached_row", int'(done), 1);
    endtask

    task automatic do_reset();
        reset = 0; set_mode(M_IDLE); inc = 0; left = 0; right = 0;
        cyc();
        reset = 1;
    endtask

    task automatic move(input logic l, input logic r);
        set_mode(M_IDLE); left = l; right = r; cyc();
        left = 0; right = 0; set_mode(M_ERASE); cyc();
        set_mode(M_IDLE); cyc();
    endtask

    task automatic probe(input string nm, input int want);
        set_mode(M_CAR); inc = 0; cyc();
        chk(nm, int'(x), want);
        set_mode(M_IDLE); cyc();
    endtask

    typedef struct {
        logic       rst;
        logic [5:0] mask;   // erase, update_car, draw_car, black, green_left, green_right
        logic       inc;
        int         ecx, ecy, ep, ex, ey, ecol;
    } vec_t;

    vec_t vt[15];

    initial begin
        vt[0]  = '{1'b0, 6'b000000, 1'b0, 0, 0, 0,   0,   0, 0};
        vt[1]  = '{1'b1, 6'b000010, 1'b0, 0, 0, 1,   0,   0, 2};
        vt[2]  = '{1'b1, 6'b000010, 1'b0, 1, 0, 1,   1,   0, 2};
        vt[3]  = '{1'b1, 6'b000010, 1'b1, 2, 0, 1,   2,   0, 2};
        vt[4]  = '{1'b1, 6'b000010, 1'b0, 0, 1, 1,   0,   1, 2};
        vt[5]  = '{1'b1, 6'b000100, 1'b0, 0, 0, 1,  30,   0, 0};
        vt[6]  = '{1'b1, 6'b000110, 1'b0, 1, 0, 1,  31,   0, 0};
        vt[7]  = '{1'b1, 6'b001000, 1'b0, 0, 0, 1,  78, 100, 4};
        vt[8]  = '{1'b1, 6'b001000, 1'b1, 1, 0, 1,  79, 100, 4};
        vt[9]  = '{1'b1, 6'b001000, 1'b0, 0, 1, 1,  78, 101, 4};
        vt[10] = '{1'b1, 6'b011000, 1'b0, 0, 0, 1,  78, 100, 4};
        vt[11] = '{1'b1, 6'b000001, 1'b0, 0, 0, 1, 130,   0, 2};
        vt[12] = '{1'b1, 6'b000000, 1'b0, 0, 0, 0,   0,   0, 0};
        vt[13] = '{1'b1, 6'b100001, 1'b0, 0, 0, 1,  30,   0, 0};
        vt[14] = '{1'b1, 6'b000000, 1'b0, 0, 0, 0,   0,   0, 0};

        @(posedge clock); #1;

        // Reset held with every strobe high.
        set_mask(6'b111111);
        for (int i = 0; i < 3; i++) begin
            reset = 0; cyc();
            chk("rst_plot", int'(plot), 0);
        end
        reset = 1; set_mode(M_IDLE); cyc();
        probe("rst_car_x", 78);

        // Vector table.
        for (int i = 0; i < 15; i++) begin
            reset = vt[i].rst; set_mask(vt[i].mask); inc = vt[i].inc;
            #1;
            chk("tbl_cx", int'(counterx), vt[i].ecx);
            chk("tbl_cy", int'(countery), vt[i].ecy);
            cyc();
            chk("tbl_plot", int'(plot), vt[i].ep);
            if (vt[i].ep == 1 || vt[i].rst == 1'b0) begin
                chk("tbl_x", int'(x), vt[i].ex);
                chk("tbl_y", int'(y), vt[i].ey);
                chk("tbl_colour", int'(colour), vt[i].ecol);
            end
        end
        inc = 0;

        // Full green-left sweep, then straight into black.
        do_reset();
        clear_stats();
        run_region(M_GL, SIDE_W, SCR_H, 4000);
        chk("gl_end_cy", int'(countery), 120);
        cyc();
        chk("gl_end_plot", int'(plot), 0);
        chk("gl_plots", plot_cnt, 3600);
        chk("gl_min_x", min_x, 0);   chk("gl_max_x", max_x, 29);
        chk("gl_min_y", min_y, 0);   chk("gl_max_y", max_y, 119);
        clear_stats();
        set_mode(M_BLK); inc = 0; #1;
        chk("sw_cx", int'(counterx), 0);
        chk("sw_cy", int'(countery), 0);
        cyc();
        chk("sw_x", int'(x), 30);
        chk("sw_y", int'(y), 0);
        run_region(M_BLK, ROAD_W, SCR_H, 13000);
        cyc();
        chk("blk_end_plot", int'(plot), 0);
        chk("blk_plots", plot_cnt, 12000);

        // Move left, full erase, then redraw the car.
        do_reset();
        set_mode(M_IDLE); left = 1; cyc(); left = 0;
        run_region(M_ERASE, ROAD_W, SCR_H, 13000);
        set_mode(M_IDLE); cyc();
        clear_stats();
        run_region(M_UPD, CAR_W, CAR_H, 200);
        chk("car_plots", plot_cnt, 65);
        chk("car_min_x", min_x, 74);  chk("car_max_x", max_x, 78);
        chk("car_min_y", min_y, 100); chk("car_max_y", max_y, 112);
        set_mode(M_IDLE); cyc();

        // Clamp at both road edges.
        do_reset();
        for (int i = 0; i < 12; i++) move(1'b1, 1'b0);
        probe("clamp_l12", 30);
        move(1'b1, 1'b0);
        probe("clamp_l13", 30);
        do_reset();
        for (int i = 0; i < 12; i++) move(1'b0, 1'b1);
        probe("clamp_r12", 125);

        // Conflicting pulses, and a pulse during the erase start cycle.
        do_reset();
        move(1'b1, 1'b1);
        probe("both_pulse", 78);
        set_mode(M_IDLE); left = 1; cyc(); left = 0;
        set_mode(M_ERASE); right = 1; cyc(); right = 0;
        set_mode(M_IDLE); cyc();
        probe("erase_pulse_now", 74);
        set_mode(M_ERASE); cyc(); set_mode(M_IDLE); cyc();
        probe("erase_pulse_next", 78);

        // Reset in the middle of a black sweep.
        move(1'b1, 1'b0);
        run_region(M_BLK, ROAD_W, 57, 7000);
        chk("mid_cy", int'(countery), 57);
        reset = 0; cyc();
        chk("mid_rst_plot", int'(plot), 0);
        reset = 1; set_mode(M_BLK); #1;
        chk("mid_rst_cx", int'(counterx), 0);
        chk("mid_rst_cy", int'(countery), 0);
        set_mode(M_IDLE); cyc();
        probe("mid_rst_car_x", 78);

        // Random stimulus against the model.
        begin
            logic [5:0] pat = 6'b0;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(15) == 0) pat = 6'($urandom_range(63) & $urandom_range(63));
                set_mask(pat);
                inc   = ($urandom_range(7) == 0);
                left  = ($urandom_range(9) == 0);
                right = ($urandom_range(9) == 0);
                reset = ($urandom_range(199) != 0);
                cyc();
            end
            reset = 1; inc = 0; left = 0; right = 0; set_mode(M_IDLE); cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
